// File: rtl/serial_digit_adder.sv
// ============================================================================
// Module   : serial_digit_adder
// Purpose  : Digit-serial adder/subtractor, DIGIT bits per clock, LSB first,
//            valid/ready handshake on operands and result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_digit_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] c_last = CW'(NDIG - 1);

  if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
    $error("serial_digit_adder: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_carry;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_s;
  logic              r_cout;
  logic              r_v;

  logic [DIGIT-1:0]  w_a_dig;
  logic [DIGIT-1:0]  w_b_dig;
  logic [DIGIT-1:0]  w_sum;
  logic              w_c_out;
  logic              w_c_msb;
  logic              w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  assign w_last = (r_cnt == c_last);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_next = ST_RUN;
      ST_RUN:  if (w_last)    w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Digit mux built from constant part-selects so every slice stays in range.
  always_comb begin
    w_a_dig = '0;
    w_b_dig = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (r_cnt == CW'(k)) begin
        w_a_dig = r_a[k*DIGIT +: DIGIT];
        w_b_dig = r_b[k*DIGIT +: DIGIT];
      end
    end
  end

  assign {w_c_out, w_sum} = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {{DIGIT{1'b0}}, r_carry};
  // Carry into the top bit of the slice is recovered from the sum bit itself.
  assign w_c_msb = w_a_dig[DIGIT-1] ^ w_b_dig[DIGIT-1] ^ w_sum[DIGIT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_v     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= A;
            r_b     <= B ^ {WIDTH{Sub}};
            r_carry <= Cin ^ Sub;
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          for (int k = 0; k < NDIG; k++) begin
            if (r_cnt == CW'(k)) begin
              r_s[k*DIGIT +: DIGIT] <= w_sum;
            end
          end
          r_carry <= w_c_out;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_cout <= w_c_out;
            r_v    <= w_c_msb ^ w_c_out;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign S         = r_s;
  assign Cout      = r_cout;
  assign V         = r_v;

endmodule

`default_nettype wire
